id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated hazard control for the 5-stage core. It captures the 11-bit decoded control word and the operands produced in decode, and presents them to execute one cycle later. It also inserts bubbles on load-use hazards and branch flushes, and holds execute for multi-cycle FPU operations. It drives the stall that freezes PC and IF/ID.

---
 rtl/cpu_ctrl_pkg.sv | 26 ++
 rtl/hazard_detect.sv | 34 +++
 rtl/id_ex_stage.sv | 118 +++++++++++
 tb/tb_id_ex_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-word definitions for the 5-stage core.
// Bit positions of the 11-bit decoded control word plus the field encodings
// used by the pipeline registers and hazard logic.
package cpu_ctrl_pkg;

    localparam int CTRL_W       = 11;

    localparam int ALUSRC_BIT   = 10;
    localparam int MEMTOREG_BIT = 9;
    localparam int REGWRITE_HI  = 8;
    localparam int REGWRITE_LO  = 7;
    localparam int MEMREAD_BIT  = 6;
    localparam int MEMWRITE_BIT = 5;
    localparam int BRANCH_BIT   = 4;
    localparam int ALU_OP_HI    = 3;
    localparam int ALU_OP_LO    = 2;
    localparam int RS1_FPU_BIT  = 1;
    localparam int RS2_FPU_BIT  = 0;

    localparam logic [1:0] REGWRITE_INT = 2'b01;
    localparam logic [1:0] REGWRITE_FP  = 2'b10;
    localparam logic [1:0] ALU_OP_FPU   = 2'b11;

    localparam logic [CTRL_W-1:0] CTRL_NOP = 11'b0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator. Flags when the instruction in ID reads a
// register that the load currently in EX has not yet produced. Register
// files are kept apart: an integer load never blocks an FP source and vice
// versa. Integer x0 never matches; FP f0 is a real register and does.
module hazard_detect
    import cpu_ctrl_pkg::*;
(
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    input  logic [CTRL_W-1:0] ctrl_ex,
    input  logic [4:0]        rd_ex,
    output logic              load_use
);

    logic       ex_is_load;
    logic       ex_is_fp;
    logic       rd_valid;
    logic       rs1_hit;
    logic       rs2_hit;

    // Compare the EX destination against both ID sources in the right file
    always_comb begin
        ex_is_load = ctrl_ex[MEMREAD_BIT] &&
                     (ctrl_ex[REGWRITE_HI:REGWRITE_LO] != 2'b00);
        ex_is_fp   = (ctrl_ex[REGWRITE_HI:REGWRITE_LO] == REGWRITE_FP);
        rd_valid   = ex_is_fp || (rd_ex != 5'd0);
        rs1_hit    = (rd_ex == rs1_id) && (ex_is_fp == ctrl_id[RS1_FPU_BIT]);
        rs2_hit    = (rd_ex == rs2_id) && (ex_is_fp == ctrl_id[RS2_FPU_BIT]);
        load_use   = ex_is_load && (ctrl_id != CTRL_NOP) && rd_valid &&
                     (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion and the fetch stall.
// Priority each cycle: flush, FPU hold, load-use bubble, normal capture.
// Optional build macro FPU_MULTICYCLE_EN: when defined, an FPU op holds EX
// for FPU_LATENCY cycles; otherwise FPU ops pass through in one cycle.
module id_ex_stage
    import cpu_ctrl_pkg::*;
#(
    parameter int FPU_LATENCY = 4,
    parameter int XLEN        = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic [XLEN-1:0]   pc_id,
    input  logic [XLEN-1:0]   rs1_data_id,
    input  logic [XLEN-1:0]   rs2_data_id,
    input  logic [XLEN-1:0]   imm_id,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    input  logic [4:0]        rd_id,
    input  logic [2:0]        funct3_id,
    input  logic [6:0]        funct7_id,
    input  logic              flush_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic [XLEN-1:0]   pc_ex,
    output logic [XLEN-1:0]   rs1_data_ex,
    output logic [XLEN-1:0]   rs2_data_ex,
    output logic [XLEN-1:0]   imm_ex,
    output logic [4:0]        rs1_ex,
    output logic [4:0]        rs2_ex,
    output logic [4:0]        rd_ex,
    output logic [2:0]        funct3_ex,
    output logic [6:0]        funct7_ex,
    output logic              stall_if_id,
    output logic              ex_busy
);

    localparam bit LATENCY_OK = (FPU_LATENCY >= 1) && (FPU_LATENCY <= 15);

    if (!LATENCY_OK) begin : g_bad_latency
        $error("id_ex_stage: FPU_LATENCY must be in 1..15");
    end

    logic load_use;
    logic busy;

    hazard_detect u_hazard_detect (
        .ctrl_id  (ctrl_id),
        .rs1_id   (rs1_id),
        .rs2_id   (rs2_id),
        .ctrl_ex  (ctrl_ex),
        .rd_ex    (rd_ex),
        .load_use (load_use)
    );

`ifdef FPU_MULTICYCLE_EN
    localparam logic [3:0] HOLD_INIT = 4'(FPU_LATENCY - 1);

    logic [3:0] hold_cnt;

    assign busy = (hold_cnt != 4'd0);

    // Hold counter: loaded when an FPU op is captured, counts down while busy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_cnt <= 4'd0;
        end else if (flush_ex) begin
            hold_cnt <= 4'd0;
        end else if (busy) begin
            hold_cnt <= hold_cnt - 4'd1;
        end else if (!load_use && (ctrl_id[ALU_OP_HI:ALU_OP_LO] == ALU_OP_FPU)) begin
            hold_cnt <= HOLD_INIT;
        end else begin
            hold_cnt <= 4'd0;
        end
    end
`else
    assign busy = 1'b0;
`endif

    assign ex_busy = busy;

    // Freeze PC and IF/ID during a hold or a load-use bubble; a flush overrides
    always_comb begin
        stall_if_id = 1'b0;
        if (!flush_ex) begin
            stall_if_id = busy || load_use;
        end
    end

    // Pipeline register: bubble on flush or load-use, hold while busy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || flush_ex || (!busy && load_use)) begin
            ctrl_ex     <= CTRL_NOP;
            pc_ex       <= '0;
            rs1_data_ex <= '0;
            rs2_data_ex <= '0;
            imm_ex      <= '0;
            rs1_ex      <= '0;
            rs2_ex      <= '0;
            rd_ex       <= '0;
            funct3_ex   <= '0;
            funct7_ex   <= '0;
        end else if (!busy) begin
            ctrl_ex     <= ctrl_id;
            pc_ex       <= pc_id;
            rs1_data_ex <= rs1_data_id;
            rs2_data_ex <= rs2_data_id;
            imm_ex      <= imm_id;
            rs1_ex      <= rs1_id;
            rs2_ex      <= rs2_id;
            rd_ex       <= rd_id;
            funct3_ex   <= funct3_id;
            funct7_ex   <= funct7_id;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, load-use bubbles, register-file
// matching, flush priority, FPU hold (when FPU_MULTICYCLE_EN is defined)
// and asynchronous reset.
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int LAT  = 4;

    localparam logic [10:0] C_ADDI = 11'b10010001000;
    localparam logic [10:0] C_ADD  = 11'b00010001000;
    localparam logic [10:0] C_LW   = 11'b11011000000;
    localparam logic [10:0] C_FLW  = 11'b11101000000;
    localparam logic [10:0] C_FUSE = 11'b00100000010;
    localparam logic [10:0] C_FPU  = 11'b00100001111;

    logic            clk;
    logic            rstn;
    logic [10:0]     ctrl_id;
    logic [XLEN-1:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
    logic [4:0]      rs1_id, rs2_id, rd_id;
    logic [2:0]      funct3_id;
    logic [6:0]      funct7_id;
    logic            flush_ex;
    logic [10:0]     ctrl_ex;
    logic [XLEN-1:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0]      rs1_ex, rs2_ex, rd_ex;
    logic [2:0]      funct3_ex;
    logic [6:0]      funct7_ex;
    logic            stall_if_id;
    logic            ex_busy;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    id_ex_stage #(.FPU_LATENCY(LAT), .XLEN(XLEN)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .ctrl_id     (ctrl_id),
        .pc_id       (pc_id),
        .rs1_data_id (rs1_data_id),
        .rs2_data_id (rs2_data_id),
        .imm_id      (imm_id),
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .rd_id       (rd_id),
        .funct3_id   (funct3_id),
        .funct7_id   (funct7_id),
        .flush_ex    (flush_ex),
        .ctrl_ex     (ctrl_ex),
        .pc_ex       (pc_ex),
        .rs1_data_ex (rs1_data_ex),
        .rs2_data_ex (rs2_data_ex),
        .imm_ex      (imm_ex),
        .rs1_ex      (rs1_ex),
        .rs2_ex      (rs2_ex),
        .rd_ex       (rd_ex),
        .funct3_ex   (funct3_ex),
        .funct7_ex   (funct7_ex),
        .stall_if_id (stall_if_id),
        .ex_busy     (ex_busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] c, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd);
        ctrl_id = c;
        rs1_id  = r1;
        rs2_id  = r2;
        rd_id   = rd;
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        ctrl_id = '0; pc_id = '0; rs1_data_id = '0; rs2_data_id = '0; imm_id = '0;
        rs1_id = '0; rs2_id = '0; rd_id = '0; funct3_id = '0; funct7_id = '0;
        flush_ex = 1'b0;

        // Reset state
        #12;
        check("reset_ctrl_ex", 32'(ctrl_ex), 32'h0);
        check("reset_stall", 32'(stall_if_id), 32'h0);
        check("reset_busy", 32'(ex_busy), 32'h0);
        check("reset_rd_ex", 32'(rd_ex), 32'h0);

        // Post-reset capture of an addi
        rstn = 1'b1;
        pc_id = 32'h0000_0100; imm_id = 32'h0000_0007; rs1_data_id = 32'hDEAD_BEEF;
        funct3_id = 3'd5; funct7_id = 7'h20;
        drive(C_ADDI, 5'd1, 5'd2, 5'd5);
        tick();
        check("addi_ctrl_ex", 32'(ctrl_ex), 32'(C_ADDI));
        check("addi_rd_ex", 32'(rd_ex), 32'd5);
        check("addi_pc_ex", pc_ex, 32'h0000_0100);
        check("addi_imm_ex", imm_ex, 32'h0000_0007);
        check("addi_rs1_data_ex", rs1_data_ex, 32'hDEAD_BEEF);
        check("addi_funct_ex", {22'd0, funct7_ex, funct3_ex}, {22'd0, 7'h20, 3'd5});
        check("addi_stall", 32'(stall_if_id), 32'h0);

        // Integer load-use: lw x3 then add reading x3 through rs2
        drive(C_LW, 5'd1, 5'd2, 5'd3);
        tick();
        drive(C_ADD, 5'd1, 5'd3, 5'd4);
        check("lu_stall", 32'(stall_if_id), 32'h1);
        exp_q.push_back(11'b0);
        exp_q.push_back(C_ADD);
        tick();
        check("lu_bubble_ctrl", 32'(ctrl_ex), 32'(exp_q.pop_front()));
        check("lu_bubble_rd", 32'(rd_ex), 32'h0);
        check("lu_selfclear", 32'(stall_if_id), 32'h0);
        tick();
        check("lu_add_ctrl", 32'(ctrl_ex), 32'(exp_q.pop_front()));
        check("lu_add_rd", 32'(rd_ex), 32'd4);

        // FP load f3: integer reader of x3 must not stall, FP reader of f3 must
        drive(C_FLW, 5'd1, 5'd2, 5'd3);
        tick();
        drive(C_ADD, 5'd3, 5'd7, 5'd4);
        check("file_mismatch_stall", 32'(stall_if_id), 32'h0);
        drive(C_FUSE, 5'd3, 5'd7, 5'd4);
        check("file_match_stall", 32'(stall_if_id), 32'h1);

        // lw x0 followed by a reader of x0: never a hazard
        drive(C_LW, 5'd9, 5'd9, 5'd0);
        check("no_hazard_before_lw0", 32'(stall_if_id), 32'h0);
        tick();
        drive(C_ADD, 5'd0, 5'd0, 5'd4);
        check("x0_no_stall", 32'(stall_if_id), 32'h0);

        // flw f0 followed by FP reader of f0: f0 is real and matches
        drive(C_FLW, 5'd9, 5'd9, 5'd0);
        tick();
        drive(C_FUSE, 5'd0, 5'd9, 5'd4);
        check("f0_stall", 32'(stall_if_id), 32'h1);
        drive(11'b0, 5'd0, 5'd0, 5'd4);
        check("nop_never_stalls", 32'(stall_if_id), 32'h0);

        // Flush beats a pending load-use
        drive(C_FUSE, 5'd0, 5'd9, 5'd4);
        flush_ex = 1'b1;
        #1;
        check("flush_stall", 32'(stall_if_id), 32'h0);
        tick();
        flush_ex = 1'b0;
        check("flush_ctrl_ex", 32'(ctrl_ex), 32'h0);
        check("flush_busy", 32'(ex_busy), 32'h0);

        // FPU op
        drive(C_FPU, 5'd1, 5'd2, 5'd8);
        tick();
        check("fpu_capture", 32'(ctrl_ex), 32'(C_FPU));
        drive(C_ADDI, 5'd1, 5'd2, 5'd6);
`ifdef FPU_MULTICYCLE_EN
        for (int i = 1; i < LAT; i++) begin
            check($sformatf("fpu_busy_%0d", i), 32'(ex_busy), 32'h1);
            check($sformatf("fpu_stall_%0d", i), 32'(stall_if_id), 32'h1);
            tick();
            check($sformatf("fpu_hold_%0d", i), 32'(ctrl_ex), 32'(C_FPU));
        end
        check("fpu_busy_end", 32'(ex_busy), 32'h0);
        check("fpu_stall_end", 32'(stall_if_id), 32'h0);
        tick();
        check("fpu_next_capture", 32'(ctrl_ex), 32'(C_ADDI));
        check("fpu_next_rd", 32'(rd_ex), 32'd6);

        // Reset asserted on the second hold cycle
        drive(C_FPU, 5'd1, 5'd2, 5'd8);
        tick();
        tick();
        check("mid_hold_busy", 32'(ex_busy), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_ctrl_ex", 32'(ctrl_ex), 32'h0);
        check("mid_rst_busy", 32'(ex_busy), 32'h0);
        check("mid_rst_stall", 32'(stall_if_id), 32'h0);
`else
        check("fpu_pass_busy", 32'(ex_busy), 32'h0);
        check("fpu_pass_stall", 32'(stall_if_id), 32'h0);
        tick();
        check("fpu_pass_next", 32'(ctrl_ex), 32'(C_ADDI));
        check("fpu_pass_rd", 32'(rd_ex), 32'd6);

        // Asynchronous reset in the middle of a cycle
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_ctrl_ex", 32'(ctrl_ex), 32'h0);
        check("mid_rst_rd_ex", 32'(rd_ex), 32'h0);
        check("mid_rst_busy", 32'(ex_busy), 32'h0);
`endif

        // Release with a nop in ID: no residual stall
        drive(11'b0, 5'd0, 5'd0, 5'd0);
        tick();
        rstn = 1'b1;
        tick();
        check("post_rst_stall", 32'(stall_if_id), 32'h0);
        check("post_rst_ctrl", 32'(ctrl_ex), 32'h0);
        drive(C_ADDI, 5'd1, 5'd2, 5'd5);
        tick();
        check("post_rst_capture", 32'(ctrl_ex), 32'(C_ADDI));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
